// File: rtl/fp_round_pack.sv
// Final FP multiplier stage: round-to-nearest-even of the normalized product,
// exception classification and IEEE-754 single-precision packing, two-stage valid/ready pipe.
module fp_round_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  exp_4,
    input  logic [47:0] norm1,
    input  logic        ov1,
    input  logic        sign2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [3:0]  sticky_flags,
    input  logic        clr_flags
);

    // Handshake: a beat transfers on any rising edge where valid and ready are both 1;
    // valid never waits on ready, and a stalled stage holds its data until it transfers.
    logic        valid_a, valid_b;
    logic        adv_a, adv_b, accept, handshake;

    assign adv_b     = !valid_b || out_ready;
    assign adv_a     = !valid_a || adv_b;
    assign in_ready  = adv_a;
    assign accept    = in_valid && in_ready;
    assign handshake = valid_b && out_ready;
    assign out_valid = valid_b;

    // Stage A input side: pick the 23 fraction bits below the leading one.
    logic [22:0] frac_in;
    logic        guard_in, sticky_in;
    logic        round_up_in, inexact_in;
    logic        zero_in, unf_in, ovf_pre_in;

    always_comb begin
        frac_in   = norm1[45:23];
        guard_in  = norm1[22];
        sticky_in = |norm1[21:0];
        if (ov1) begin
            frac_in   = norm1[46:24];
            guard_in  = norm1[23];
            sticky_in = |norm1[22:0];
        end
    end

    assign round_up_in = guard_in && (sticky_in || frac_in[0]);
    assign inexact_in  = guard_in || sticky_in;
    assign zero_in     = (norm1 == 48'd0);
    assign unf_in      = (exp_4 == 9'd0);
    assign ovf_pre_in  = (exp_4 >= 9'd255);

    logic        sign_a, round_up_a, inexact_a, zero_a, unf_a, ovf_pre_a;
    logic [8:0]  exp_a;
    logic [22:0] frac_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_a    <= 1'b0;
            sign_a     <= 1'b0;
            exp_a      <= 9'd0;
            frac_a     <= 23'd0;
            round_up_a <= 1'b0;
            inexact_a  <= 1'b0;
            zero_a     <= 1'b0;
            unf_a      <= 1'b0;
            ovf_pre_a  <= 1'b0;
        end else if (adv_a) begin
            valid_a <= in_valid;
            if (in_valid) begin
                sign_a     <= sign2;
                exp_a      <= exp_4;
                frac_a     <= frac_in;
                round_up_a <= round_up_in;
                inexact_a  <= inexact_in;
                zero_a     <= zero_in;
                unf_a      <= unf_in;
                ovf_pre_a  <= ovf_pre_in;
            end
        end
    end

    // Stage B input side: apply the rounding increment; a carry out of the
    // 23-bit fraction leaves it zero and bumps the exponent.
    logic [23:0] sum_b;
    logic        carry_b;
    logic [8:0]  exp_rnd;
    logic [31:0] result_nxt;
    logic [3:0]  flags_nxt;

    assign sum_b   = {1'b0, frac_a} + {23'd0, round_up_a};
    assign carry_b = sum_b[23];
    assign exp_rnd = exp_a + {8'd0, carry_b};

    always_comb begin
        result_nxt = {sign_a, exp_rnd[7:0], sum_b[22:0]};
        flags_nxt  = {1'b0, 1'b0, inexact_a, 1'b0};
        if (zero_a) begin
            result_nxt = {sign_a, 31'd0};
            flags_nxt  = 4'b0001;
        end else if (unf_a) begin
            result_nxt = {sign_a, 31'd0};
            flags_nxt  = 4'b0110;
        end else if (ovf_pre_a || exp_rnd == 9'd255) begin
            result_nxt = {sign_a, 8'hFF, 23'd0};
            flags_nxt  = 4'b1010;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_b <= 1'b0;
            result  <= 32'd0;
            flags   <= 4'd0;
        end else if (adv_b) begin
            valid_b <= valid_a;
            if (valid_a) begin
                result <= result_nxt;
                flags  <= flags_nxt;
            end
        end
    end

    // A clear coinciding with a handshake keeps that handshake's flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= 4'd0;
        end else if (handshake) begin
            sticky_flags <= clr_flags ? flags : (sticky_flags | flags);
        end else if (clr_flags) begin
            sticky_flags <= 4'd0;
        end
    end

endmodule

// File: doc/fp_round_pack.md
# fp_round_pack

Final stage of the floating-point multiplier pipeline. It consumes the registered normalized product (biased exponent, 48-bit significand product, overflow bit, sign) and rounds the significand to 24 bits using round-to-nearest-even. It then handles exponent overflow, underflow and zero, and packs an IEEE-754 single-precision result. The block is a two-stage valid/ready pipeline with per-result exception flags and sticky accumulated flags.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input this cycle.
- exp_4  input  9  biased exponent, unsigned, already incremented when ov1=1.
- norm1  input  48  significand product, bit 47 = 2^1 position.
- ov1  input  1  product ≥ 2.0; leading one at bit 47, else at bit 46.
- sign2  input  1  result sign.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  32  packed {sign, exp[7:0], frac[22:0]}.
- flags  output  4  {overflow, underflow, inexact, zero} for the current result.
- sticky_flags  output  4  OR of flags over all accepted results since the last clear.
- clr_flags  input  1  synchronous clear of sticky_flags.

## Operation
- Field select when ov1=1: frac = norm1[46:24], guard = norm1[23], sticky = |norm1[22:0].
- Field select when ov1=0: frac = norm1[45:23], guard = norm1[22], sticky = |norm1[21:0].
- Round-up: guard & (sticky | frac[0]). Inexact = guard | sticky.
- The increment is 24-bit: {1'b0,frac} + round_up. On carry out, frac becomes 0 and the exponent increments by 1.
- Classification is evaluated in the priority order below.
  1. zero: norm1 == 0. Result = {sign2, 31'b0}; flags = zero only.
  2. underflow: exp_4 == 0, evaluated before rounding. Denormals are flushed. Result = {sign2, 31'b0}; underflow=1; inexact=1.
  3. overflow: exp_4 ≥ 255, or the exponent after rounding carry == 255. Result = {sign2, 8'hFF, 23'b0}; overflow=1; inexact=1.
  4. normal: result = {sign2, exp[7:0], rounded frac}; inexact as computed.
- Stage A registers the following: sign, exp_4, frac, round_up, inexact, and the zero/underflow/overflow-pre class.
- Stage B registers the following: packed result and flags.
- sticky_flags |= flags on each output handshake (out_valid & out_ready).
- If clr_flags is asserted in the same cycle as a handshake, sticky_flags loads that handshake's flags; the clear does not win outright.

## Timing
- Reset, asynchronous: every output and register goes to 0 immediately. This applies to valid_A, valid_B, out_valid, result, flags and sticky_flags.
- in_ready = !valid_A | !valid_B | out_ready. Data is in flight only when valid bits are set.
- Stage B advance = !valid_B | out_ready.
- Stage A advance = !valid_A | stage B advance.
- Input accept = in_valid & in_ready.
- Latency is 2 cycles: an input accepted at edge N produces out_valid at edge N+2 if there is no stall.
- Throughput is 1 per cycle with out_ready held high.
- Bubbles collapse: an empty stage accepts data even while the downstream stage is stalled.
- While out_valid=1 and out_ready=0, result and flags hold stable.
- Results leave in input order. No result is dropped or duplicated.
- Reset mid-operation discards all in-flight beats. The first beat accepted after reset release appears 2 cycles later.

## Test plan
- 1.0×1.0: exp_4=127, norm1=48'h400000000000, ov1=0, sign2=0.
  - Required: result 32'h3F800000 and flags 0 exactly 2 cycles later.
- Rounding carry: exp_4=127, norm1=48'h7FFFFFC00000, ov1=0.
  - Required: result 32'h40000000, inexact=1.
  - Tie to even: norm1=48'h400000400000 → 32'h3F800000, inexact=1, no round-up.
- Overflow: exp_4=255, sign2=1, norm1=48'h400000000000 → result 32'hFF800000, flags {1,0,1,0}.
  - Underflow: exp_4=0 → 32'h00000000 (sign2=0), flags {0,1,1,0}.
  - Zero: norm1=0 → 32'h80000000 (sign2=1), flags 4'b0001.
- Backpressure: stream 5 inputs back-to-back with out_ready=0 for cycles 2–5.
  - Required: in_ready=0 once both stages are full, result held stable, all 5 results emerge in order after out_ready=1.
  - Required: sticky_flags equals the OR of the flags of results emitted so far.
- Reset with 2 beats in flight: assert reset low for 1 cycle.
  - Required: out_valid, result and sticky_flags are 0 at once and no stale result appears afterwards.
  - Required: clr_flags alone clears sticky_flags on the next edge.
